// File: rtl/store_buffer.sv
// Store FIFO in front of the data memory: drains one store per cycle, forwards or stalls loads.
// Build option SB_FORWARD_EN: when defined, exact-covering stores forward to loads; otherwise any overlap stalls.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_type,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  output logic        ld_hit,
  output logic [31:0] ld_fwd_data,
  output logic        ld_stall,
  output logic        mem_store,
  output logic        mem_load,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [2:0]  mem_type,
  output logic        empty
);

  logic [31:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [2:0]       r_type [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_full, w_push, w_pop, w_ovl;
  logic [PTR_W-1:0] w_idx;
  logic [3:0]       w_ld_lanes;
`ifdef SB_FORWARD_EN
  logic             w_cover;
  logic [31:0]      w_fwd_src;
`endif

  // Byte-size mask of an access; numeric order doubles as a width compare.
  function automatic logic [3:0] f_size(input logic [2:0] t);
    case (t)
      3'b000, 3'b011: f_size = 4'b0001;
      3'b001, 3'b100: f_size = 4'b0011;
      3'b010:         f_size = 4'b1111;
      default:        f_size = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] f_lanes(input logic [2:0] t, input logic [1:0] off);
    return f_size(t) << off;
  endfunction

`ifdef SB_FORWARD_EN
  function automatic logic [31:0] f_ext(input logic [31:0] d, input logic [2:0] t);
    case (t)
      3'b000:  f_ext = {{24{d[7]}}, d[7:0]};
      3'b001:  f_ext = {{16{d[15]}}, d[15:0]};
      3'b011:  f_ext = {24'h0, d[7:0]};
      3'b100:  f_ext = {16'h0, d[15:0]};
      default: f_ext = d;
    endcase
  endfunction
`endif

  assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign st_ready = !w_full;
  assign empty    = (r_count == '0);
  // Invalid store types handshake normally but never allocate.
  assign w_push   = st_valid && st_ready && (st_type <= 3'b010);
  assign w_pop    = mem_store;

  // Scan oldest to youngest so the last overlapping entry (the youngest) decides.
  always_comb begin
    w_ovl      = 1'b0;
    w_idx      = '0;
    w_ld_lanes = f_lanes(ld_type, ld_addr[1:0]);
`ifdef SB_FORWARD_EN
    w_cover    = 1'b0;
    w_fwd_src  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (ld_valid && r_vld[w_idx] && (r_addr[w_idx][31:2] == ld_addr[31:2]) &&
          |(f_lanes(r_type[w_idx], r_addr[w_idx][1:0]) & w_ld_lanes)) begin
        w_ovl = 1'b1;
`ifdef SB_FORWARD_EN
        w_cover   = (r_addr[w_idx] == ld_addr) && (f_size(r_type[w_idx]) >= f_size(ld_type));
        w_fwd_src = r_data[w_idx];
`endif
      end
    end
  end

`ifdef SB_FORWARD_EN
  assign ld_hit      = w_ovl && w_cover;
  assign ld_stall    = w_ovl && !w_cover;
  assign ld_fwd_data = ld_hit ? f_ext(w_fwd_src, ld_type) : 32'h0;
`else
  assign ld_hit      = 1'b0;
  assign ld_stall    = w_ovl;
  assign ld_fwd_data = 32'h0;
`endif

  // A stalled load does not claim the bus, so the blocking store can drain.
  assign mem_load  = ld_valid && !ld_hit && !ld_stall;
  assign mem_store = !empty && !mem_load;
  assign mem_addr  = mem_load ? ld_addr : r_addr[r_head];
  assign mem_type  = mem_load ? ld_type : r_type[r_head];
  assign mem_data  = r_data[r_head];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_type[r_tail] <= st_type;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a store scoreboard; forwarding expectations follow SB_FORWARD_EN.
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_type;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        ld_hit, ld_stall;
  logic [31:0] ld_fwd_data;
  logic        mem_store, mem_load;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  mem_type;
  logic        empty;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  t;
  } st_t;
  st_t sb[$];
  int  vecs = 0;
  int  errs = 0;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_type(ld_type),
    .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .mem_store(mem_store), .mem_load(mem_load), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_type(mem_type), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    st_valid = v; st_addr = a; st_data = d; st_type = t;
  endtask

  task automatic drv_ld(input logic v, input logic [31:0] a, input logic [2:0] t);
    ld_valid = v; ld_addr = a; ld_type = t;
  endtask

  // One cycle: check outputs at negedge against expectations and the scoreboard, then clock.
  task automatic tick(input logic e_hit, input logic e_stall, input logic [31:0] e_fwd);
    logic e_load, e_store, acc;
    int   n;
    st_t  e;
    @(negedge clk);
    n       = sb.size();
    e_load  = ld_valid && !e_hit && !e_stall;
    e_store = (n > 0) && !e_load;
    chk("st_ready", st_ready, n < DEPTH);
    chk("empty", empty, n == 0);
    chk("ld_hit", ld_hit, e_hit);
    chk("ld_stall", ld_stall, e_stall);
    if (e_hit) chk("ld_fwd_data", ld_fwd_data, e_fwd);
    chk("mem_load", mem_load, e_load);
    if (e_load) begin
      chk("mem_addr_ld", mem_addr, ld_addr);
      chk("mem_type_ld", mem_type, ld_type);
    end
    chk("mem_store", mem_store, e_store);
    if (e_store) begin
      e = sb.pop_front();
      chk("mem_addr_st", mem_addr, e.a);
      chk("mem_data_st", mem_data, e.d);
      chk("mem_type_st", mem_type, e.t);
    end
    acc = st_valid && (n < DEPTH) && (st_type <= 3'b010);
    @(posedge clk);
    if (acc) sb.push_back('{st_addr, st_data, st_type});
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b1, 32'h100, 3'b010);
    #2;
    chk("rst_fwd", ld_fwd_data, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    drv_ld(1'b0, 32'h0, 3'b010);

    // single store drains next cycle
    drv_st(1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    // fill while a load owns the bus, then drain; full blocks even while popping
    drv_ld(1'b1, 32'h200, 3'b010);
    for (int i = 0; i < DEPTH; i++) begin
      drv_st(1'b1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), 3'b010);
      tick(1'b0, 1'b0, 32'h0);
    end
    drv_st(1'b1, 32'h110, 32'hA4, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_ld(1'b0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    // invalid store type is accepted and dropped
    drv_st(1'b1, 32'h14, 32'h12, 3'b011);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);

    // LB / LBU forwarding from a buffered SW
    drv_ld(1'b1, 32'h300, 3'b010);
    drv_st(1'b1, 32'h40, 32'h12345678, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b1, 32'h20, 32'h8000FF80, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b1, 32'h20, 3'b000);
    tick(FWD, !FWD, 32'hFFFFFF80);
    drv_ld(1'b1, 32'h20, 3'b011);
    tick(FWD, !FWD, 32'h00000080);
    drv_ld(1'b0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);

    // partial overlap stalls until the SB drains
    drv_st(1'b1, 32'h22, 32'h0000007F, 3'b000);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b1, 32'h20, 3'b010);
    tick(1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    // store pushed this cycle is invisible to the load
    drv_st(1'b1, 32'h50, 32'h55, 3'b010);
    drv_ld(1'b1, 32'h50, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);

    // youngest overlapping store wins
    drv_ld(1'b1, 32'h300, 3'b010);
    drv_st(1'b1, 32'h30, 32'h11111111, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b1, 32'h30, 32'h22222222, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b1, 32'h30, 3'b010);
    tick(FWD, !FWD, 32'h22222222);
    drv_ld(1'b1, 32'h32, 3'b001);
    tick(1'b0, 1'b1, 32'h0);
    drv_ld(1'b0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);

    // asynchronous reset with three entries buffered
    drv_ld(1'b1, 32'h300, 3'b010);
    for (int i = 0; i < 3; i++) begin
      drv_st(1'b1, 32'h60 + 32'(4*i), 32'hC0 + 32'(i), 3'b010);
      tick(1'b0, 1'b0, 32'h0);
    end
    drv_st(1'b0, 32'h0, 32'h0, 3'b010);
    drv_ld(1'b1, 32'h60, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_store", mem_store, 1'b0);
    chk("arst_ld_hit", ld_hit, 1'b0);
    chk("arst_ld_stall", ld_stall, 1'b0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_mem_load", mem_load, 1'b1);
    sb.delete();
    tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    drv_ld(1'b0, 32'h0, 3'b010);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
